// File: rtl/cache_mem_arbiter.sv
// Arbitrates the shared sram-like memory port between i-cache and d-cache.
// Build option: CACHE_ARB_RR_EN selects round-robin grant instead of data priority.
module cache_mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_WIDTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok
);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } state_e;

  state_e state_q, state_d;
  logic   owner_q, owner_d;
  logic   gnt_data;
  logic   owner_req;
  logic   addr_hs;
  logic   data_hs;

`ifdef CACHE_ARB_RR_EN
  logic last_owner_q, last_owner_d;
`else
  localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(STARVE_LIMIT);
  logic [CNT_WIDTH-1:0] starve_cnt_q, starve_cnt_d;
`endif

  // Read data is broadcast; only the owner's data_ok qualifies it.
  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;

  // Winner of the next arbitration (1 = data).
  always_comb begin
`ifdef CACHE_ARB_RR_EN
    gnt_data = data_req & (~inst_req | ~last_owner_q);
`else
    gnt_data = data_req & ~(inst_req & (starve_cnt_q == LIMIT));
`endif
  end

  // Request mux towards memory and handshake routing back to the owner.
  always_comb begin
    owner_req    = owner_q ? data_req   : inst_req;
    mem_wr       = owner_q ? data_wr    : inst_wr;
    mem_size     = owner_q ? data_size  : inst_size;
    mem_addr     = owner_q ? data_addr  : inst_addr;
    mem_wdata    = owner_q ? data_wdata : inst_wdata;
    inst_addr_ok = addr_hs & ~owner_q;
    data_addr_ok = addr_hs &  owner_q;
    inst_data_ok = data_hs & ~owner_q;
    data_data_ok = data_hs &  owner_q;
  end

  // Next-state, grant bookkeeping and handshake pulses.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    mem_req = 1'b0;
    addr_hs = 1'b0;
    data_hs = 1'b0;
`ifdef CACHE_ARB_RR_EN
    last_owner_d = last_owner_q;
`else
    starve_cnt_d = starve_cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (inst_req | data_req) begin
          state_d = ADDR;
          owner_d = gnt_data;
`ifdef CACHE_ARB_RR_EN
          last_owner_d = gnt_data;
`else
          if (gnt_data & inst_req) begin
            if (starve_cnt_q != LIMIT)
              starve_cnt_d = starve_cnt_q + CNT_WIDTH'(1);
          end else begin
            starve_cnt_d = '0;
          end
`endif
        end
      end
      ADDR: begin
        mem_req = owner_req;
        if (!owner_req) begin
          state_d = IDLE;
        end else if (mem_addr_ok) begin
          addr_hs = 1'b1;
          if (mem_data_ok) begin
            data_hs = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (mem_data_ok) begin
          data_hs = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and grant registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
`ifdef CACHE_ARB_RR_EN
      last_owner_q <= 1'b0;
`else
      starve_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
`ifdef CACHE_ARB_RR_EN
      last_owner_q <= last_owner_d;
`else
      starve_cnt_q <= starve_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: vector table, corner sequences, random vs model.
// Follows CACHE_ARB_RR_EN like the design.
module tb_cache_mem_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic [31:0] inst_rdata, data_rdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_addr_ok, mem_data_ok;

  int n_cmp = 0;
  int n_bad = 0;

  cache_mem_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic clr_inputs();
    inst_req = 0; inst_wr = 0; inst_size = 2'd2;
    inst_addr = '0; inst_wdata = '0;
    data_req = 0; data_wr = 0; data_size = 2'd2;
    data_addr = '0; data_wdata = '0;
    mem_rdata = '0; mem_addr_ok = 0; mem_data_ok = 0;
  endtask

  task automatic do_reset();
    step();
    rst = 1;
    clr_inputs();
    step();
    step();
    rst = 0;
  endtask

  // Called at negedge+2 of the first mem_req cycle of a grant.
  // la: cycles until addr_ok; ld: cycles from addr_ok to data_ok.
  task automatic serve(input logic own, input int la, input int ld,
                       input logic [31:0] rd, input bit drop);
    for (int i = 0; i < la; i++) begin
      step(); #2;
      chk("addr_wait_req", mem_req, 1);
      chk("addr_wait_ok", {inst_addr_ok, data_addr_ok}, 0);
    end
    mem_addr_ok = 1;
    if (ld == 0) begin
      mem_data_ok = 1;
      mem_rdata = rd;
    end
    #1;
    chk("own_addr_ok", own ? data_addr_ok : inst_addr_ok, 1);
    chk("oth_addr_ok", own ? inst_addr_ok : data_addr_ok, 0);
    chk("oth_data_ok", own ? inst_data_ok : data_data_ok, 0);
    if (ld == 0) begin
      chk("own_data_ok0", own ? data_data_ok : inst_data_ok, 1);
      chk("rdata0", own ? data_rdata : inst_rdata, rd);
    end
    step();
    mem_addr_ok = 0;
    mem_data_ok = 0;
    if (drop) begin
      if (own) data_req = 0;
      else inst_req = 0;
    end
    if (ld > 0) begin
      for (int i = 1; i < ld; i++) begin
        #2;
        chk("data_wait", {mem_req, inst_data_ok, data_data_ok}, 0);
        step();
      end
      mem_data_ok = 1;
      mem_rdata = rd;
      #1;
      chk("own_data_ok", own ? data_data_ok : inst_data_ok, 1);
      chk("oth_data_ok2", own ? inst_data_ok : data_data_ok, 0);
      chk("rdata", own ? data_rdata : inst_rdata, rd);
      step();
      mem_data_ok = 0;
    end
    #2;
    chk("idle_gap", mem_req, 0);
  endtask

  typedef struct {
    logic        ireq;
    logic        dreq;
    logic [31:0] iaddr;
    logic [31:0] daddr;
    logic        dwr;
    int          la;
    int          ld;
    logic [31:0] rd;
    logic        exp_own;
  } vec_t;

  vec_t vecs[6];

  // Reference model state (transaction level).
  bit          m_act, m_adone, m_who, m_own, m_last;
  int          m_streak;
  int          ic_st, dc_st;

  function automatic logic pick_data(input logic ir, input logic dr);
`ifdef CACHE_ARB_RR_EN
    if (ir && dr) return (m_last == 1'b0);
    return dr;
`else
    if (ir && dr && m_streak == LIMIT) return 1'b0;
    return dr;
`endif
  endfunction

  task automatic model_grant(input logic ir, input logic dr);
    logic w;
    w = pick_data(ir, dr);
    m_act = 1; m_adone = 0; m_who = w; m_own = w;
    m_last = w;
    if (w && ir) m_streak = (m_streak < LIMIT) ? m_streak + 1 : LIMIT;
    else m_streak = 0;
  endtask

  task automatic run_random(input int cycles);
    logic oreq, ia, da, id, dd, er;
    logic [66:0] em;
    m_act = 0; m_adone = 0; m_who = 0; m_own = 0; m_last = 0;
    m_streak = 0; ic_st = 0; dc_st = 0;
    for (int c = 0; c < cycles; c++) begin
      step();
      if (ic_st == 1 && $urandom % 50 == 0) ic_st = 0;
      if (dc_st == 1 && $urandom % 50 == 0) dc_st = 0;
      if (ic_st == 0 && $urandom % 4 == 0) begin
        ic_st = 1;
        inst_addr = $urandom; inst_wdata = $urandom;
        inst_wr = 1'($urandom % 2); inst_size = 2'($urandom % 4);
      end
      if (dc_st == 0 && $urandom % 3 == 0) begin
        dc_st = 1;
        data_addr = $urandom; data_wdata = $urandom;
        data_wr = 1'($urandom % 2); data_size = 2'($urandom % 4);
      end
      inst_req = (ic_st == 1);
      data_req = (dc_st == 1);
      mem_rdata = $urandom;
      mem_addr_ok = 0;
      mem_data_ok = 0;
      if (!m_act) begin
        mem_addr_ok = ($urandom % 16 == 0);
        mem_data_ok = ($urandom % 16 == 0);
      end else if (!m_adone) begin
        mem_addr_ok = ($urandom % 3 == 0);
        mem_data_ok = mem_addr_ok && ($urandom % 4 == 0);
      end else begin
        mem_data_ok = ($urandom % 3 == 0);
      end
      #2;
      er = 0; ia = 0; da = 0; id = 0; dd = 0;
      oreq = m_who ? data_req : inst_req;
      if (m_act && !m_adone) begin
        er = oreq;
        if (oreq && mem_addr_ok) begin
          if (m_who) da = 1; else ia = 1;
          if (mem_data_ok) begin
            if (m_who) dd = 1; else id = 1;
          end
        end
      end else if (m_act && mem_data_ok) begin
        if (m_who) dd = 1; else id = 1;
      end
      em = m_own ? {data_wr, data_size, data_addr, data_wdata}
                 : {inst_wr, inst_size, inst_addr, inst_wdata};
      chk("rnd_hs",
          {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok},
          {er, ia, da, id, dd});
      chk("rnd_mem", {mem_wr, mem_size, mem_addr, mem_wdata}, em);
      chk("rnd_rdata", {inst_rdata, data_rdata}, {mem_rdata, mem_rdata});
      if (!m_act) begin
        if (inst_req || data_req) model_grant(inst_req, data_req);
      end else if (!m_adone) begin
        if (!oreq) m_act = 0;
        else if (mem_addr_ok) begin
          if (mem_data_ok) m_act = 0;
          else m_adone = 1;
        end
      end else if (mem_data_ok) begin
        m_act = 0;
      end
      if (ia) ic_st = id ? 0 : 2;
      else if (id) ic_st = 0;
      if (da) dc_st = dd ? 0 : 2;
      else if (dd) dc_st = 0;
    end
    step();
    clr_inputs();
    step(); step(); step();
  endtask

  initial begin
    logic [31:0] ea;
    logic        ew;
    logic        seq[6];
    rst = 1;
    clr_inputs();
    #2;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_hs", {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 0);
    inst_addr = 32'h1111_2222; data_addr = 32'h3333_4444;
    #1;
    chk("rst_mux_owner0", mem_addr, 32'h1111_2222);
    clr_inputs();
    step(); step();
    rst = 0;

    // Vector table: single arbitrations from a known idle state.
    vecs[0] = '{1, 0, 32'hBFC0_0000, 32'h0, 0, 1, 2, 32'h3C08_0001, 0};
    vecs[1] = '{0, 1, 32'h0, 32'h8000_0100, 1, 0, 3, 32'hCAFE_0001, 1};
    vecs[2] = '{1, 1, 32'hBFC0_0010, 32'h8000_0200, 0, 2, 0, 32'hCAFE_0002, 1};
`ifdef CACHE_ARB_RR_EN
    vecs[3] = '{1, 1, 32'hBFC0_0020, 32'h8000_0300, 1, 0, 0, 32'hCAFE_0003, 1};
`else
    vecs[3] = '{1, 1, 32'hBFC0_0020, 32'h8000_0300, 1, 0, 0, 32'hCAFE_0003, 1};
`endif
    vecs[4] = '{1, 0, 32'hBFC0_0030, 32'h0, 0, 3, 1, 32'hCAFE_0004, 0};
    vecs[5] = '{0, 1, 32'h0, 32'h8000_0500, 0, 1, 1, 32'hCAFE_0005, 1};
`ifdef CACHE_ARB_RR_EN
    vecs[2].exp_own = 0;
`endif
    for (int v = 0; v < 6; v++) begin
      step();
      inst_req = vecs[v].ireq; inst_addr = vecs[v].iaddr; inst_wr = 0;
      data_req = vecs[v].dreq; data_addr = vecs[v].daddr;
      data_wr = vecs[v].dwr; data_wdata = 32'h1234_0000 + v;
      #2;
      chk("vec_grant_latency", mem_req, 0);
      step();
      if (vecs[v].exp_own) inst_req = 0;
      else data_req = 0;
      #2;
      ea = vecs[v].exp_own ? vecs[v].daddr : vecs[v].iaddr;
      ew = vecs[v].exp_own ? vecs[v].dwr : 1'b0;
      chk("vec_mem_req", mem_req, 1);
      chk("vec_mem_addr", mem_addr, ea);
      chk("vec_mem_wr", mem_wr, ew);
      serve(vecs[v].exp_own, vecs[v].la, vecs[v].ld, vecs[v].rd, 1);
    end

    // Simultaneous requests: data write first, inst after an idle cycle.
    do_reset();
    inst_req = 1; inst_addr = 32'hBFC0_0040;
    data_req = 1; data_wr = 1; data_addr = 32'h8000_0010;
    data_wdata = 32'hDEAD_BEEF;
    step(); #2;
    chk("both_first_addr", mem_addr, 32'h8000_0010);
    chk("both_first_wr", mem_wr, 1);
    chk("both_first_wdata", mem_wdata, 32'hDEAD_BEEF);
    serve(1, 1, 2, 32'h0, 1);
    step(); #2;
    chk("both_second_req", mem_req, 1);
    chk("both_second_addr", mem_addr, 32'hBFC0_0040);
    serve(0, 0, 1, 32'h5555_AAAA, 1);

    // Both requesters held continuously.
    do_reset();
`ifdef CACHE_ARB_RR_EN
    seq = '{1, 0, 1, 0, 1, 0};
`else
    seq = '{1, 1, 1, 1, 0, 1};
`endif
    inst_req = 1; inst_addr = 32'hBFC0_0100;
    data_req = 1; data_addr = 32'h8000_0100;
    for (int k = 0; k < 6; k++) begin
      step(); #2;
      chk("held_req", mem_req, 1);
      chk("held_owner_addr", mem_addr,
          seq[k] ? 32'h8000_0100 : 32'hBFC0_0100);
      serve(seq[k], 0, 1, 32'h100 + k, 0);
    end
    step();
    clr_inputs();
    step(); step();

    // Reset while waiting for data; late data_ok must be ignored.
    do_reset();
    inst_req = 1; inst_addr = 32'hBFC0_0200;
    step(); #2;
    chk("rst_seq_req", mem_req, 1);
    mem_addr_ok = 1;
    step();
    mem_addr_ok = 0; inst_req = 0;
    #2;
    chk("rst_seq_in_data", mem_req, 0);
    rst = 1;
    #1;
    chk("rst_seq_async", {mem_req, inst_data_ok, data_data_ok}, 0);
    step();
    rst = 0;
    step(); step();
    mem_data_ok = 1;
    #1;
    chk("rst_seq_stray", {mem_req, inst_addr_ok, data_addr_ok,
                          inst_data_ok, data_data_ok}, 0);
    step();
    mem_data_ok = 0;
    #2;
    chk("rst_seq_idle", mem_req, 0);

    do_reset();
    run_random(3000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
